demultiplexador: RTL and testbench

- Registered 1-to-4 demultiplexer; the distribution counterpart of the 4:1 datapath multiplexer.
- Accepts one WIDTH-bit word from the shared bus together with a 2-bit destination select.
- Latches the word into one of four single-entry holding slots (A, B, C, D) using a valid/ready handshake on the input side.
- Each slot is drained independently by its consumer through a per-slot acknowledge.

---
 rtl/demultiplexador.sv | 89 ++++++++
 tb/tb_demultiplexador.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/demultiplexador.sv
// demultiplexador
// Registered 1-to-4 demultiplexer. A word offered on the shared bus is
// latched into one of four single-entry holding slots (A..D), selected by
// p_Control. The input side uses a valid/ready handshake, and each slot is
// drained independently through its own acknowledge.
//
// Ports
//   p_Clock               system clock, rising edge
//   p_Reset               synchronous, active-high reset
//   p_In[WIDTH-1:0]       word to distribute
//   p_Control[1:0]        destination select: 0=A 1=B 2=C 3=D
//   p_Valid               producer offers p_In/p_Control this cycle
//   p_Ready               selected slot can take the offer (combinational)
//   p_A..p_D              slot data registers
//   p_ValidA..p_ValidD    slot holds an unconsumed word
//   p_AckA..p_AckD        consumer takes the slot word this cycle
module demultiplexador #(
  parameter int WIDTH = 16
) (
  input  logic             p_Clock,
  input  logic             p_Reset,
  input  logic [WIDTH-1:0] p_In,
  input  logic [1:0]       p_Control,
  input  logic             p_Valid,
  output logic             p_Ready,
  output logic [WIDTH-1:0] p_A,
  output logic [WIDTH-1:0] p_B,
  output logic [WIDTH-1:0] p_C,
  output logic [WIDTH-1:0] p_D,
  output logic             p_ValidA,
  output logic             p_ValidB,
  output logic             p_ValidC,
  output logic             p_ValidD,
  input  logic             p_AckA,
  input  logic             p_AckB,
  input  logic             p_AckC,
  input  logic             p_AckD
);

  logic [WIDTH-1:0] slot_data [4];
  logic [3:0]       slot_full;
  logic [3:0]       slot_ack;
  logic [3:0]       slot_wr;
  logic             accept;

  assign slot_ack = {p_AckD, p_AckC, p_AckB, p_AckA};

  // A full slot can still accept when it is being drained in the same
  // cycle, so a steady stream into one slot runs at one word per cycle.
  assign p_Ready = !p_Reset && (!slot_full[p_Control] || slot_ack[p_Control]);
  assign accept  = p_Valid && p_Ready;

  always_comb begin
    slot_wr = 4'b0000;
    if (accept) begin
      slot_wr[p_Control] = 1'b1;
    end
  end

  always_ff @(posedge p_Clock) begin
    if (p_Reset) begin
      slot_full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (slot_wr[i]) begin
          // Write wins over ack: refill keeps the slot full.
          slot_data[i] <= p_In;
          slot_full[i] <= 1'b1;
        end else if (slot_ack[i]) begin
          // Data is left in place; consumers qualify with the valid bit.
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  assign p_A      = slot_data[0];
  assign p_B      = slot_data[1];
  assign p_C      = slot_data[2];
  assign p_D      = slot_data[3];
  assign p_ValidA = slot_full[0];
  assign p_ValidB = slot_full[1];
  assign p_ValidC = slot_full[2];
  assign p_ValidD = slot_full[3];

endmodule

// File: tb/tb_demultiplexador.sv
module tb_demultiplexador;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic [1:0]  ctl;
  logic        vld;
  logic        rdy;
  logic [15:0] qa, qb, qc, qd;
  logic        va, vb, vc, vd;
  logic        aa, ab, ac, ad;

  int n_checks;
  int n_errors;

  // Reference model: what each consumer should see in its slot.
  logic [15:0] m_data [4];
  logic        m_full [4];

  demultiplexador #(.WIDTH(16)) dut (
    .p_Clock(clk), .p_Reset(rst), .p_In(din), .p_Control(ctl),
    .p_Valid(vld), .p_Ready(rdy),
    .p_A(qa), .p_B(qb), .p_C(qc), .p_D(qd),
    .p_ValidA(va), .p_ValidB(vb), .p_ValidC(vc), .p_ValidD(vd),
    .p_AckA(aa), .p_AckB(ab), .p_AckC(ac), .p_AckD(ad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dut_data(input int i);
    case (i)
      0: return qa;
      1: return qb;
      2: return qc;
      default: return qd;
    endcase
  endfunction

  function automatic logic dut_full(input int i);
    case (i)
      0: return va;
      1: return vb;
      2: return vc;
      default: return vd;
    endcase
  endfunction

  logic last_accept;

  // One clock cycle: drive inputs, check ready, clock, update model, check slots.
  task automatic step(input logic r, input logic v, input logic [15:0] d,
                      input logic [1:0] c, input logic [3:0] ack);
    logic exp_rdy;
    @(negedge clk);
    rst = r; vld = v; din = d; ctl = c;
    {ad, ac, ab, aa} = ack;
    #1;
    // A slot is available if empty or being drained right now.
    exp_rdy = !r && (!m_full[c] || ack[c]);
    check("ready", {31'd0, rdy}, {31'd0, exp_rdy});
    @(posedge clk);
    last_accept = v && exp_rdy;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = 16'h0000;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) m_full[i] = 1'b0;
      end
      if (last_accept) begin
        m_data[c] = d;
        m_full[c] = 1'b1;
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("data%0d", i), {16'd0, dut_data(i)}, {16'd0, m_data[i]});
      check($sformatf("valid%0d", i), {31'd0, dut_full(i)}, {31'd0, m_full[i]});
    end
  endtask

  initial begin
    logic        r_v, h_v;
    logic [15:0] h_d;
    logic [1:0]  h_c;
    logic [3:0]  r_ack;
    logic        hold;

    n_checks = 0;
    n_errors = 0;
    last_accept = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 16'h0000;
      m_full[i] = 1'b0;
    end
    rst = 1'b1; vld = 1'b0; din = 16'h0; ctl = 2'd0;
    {ad, ac, ab, aa} = 4'b0000;

    // Reset with an offer pending: nothing latched, ready low.
    step(1'b1, 1'b1, 16'h1234, 2'd0, 4'b0000);
    step(1'b1, 1'b1, 16'h1234, 2'd0, 4'b0000);
    @(negedge clk);
    rst = 1'b0; vld = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, rdy}, 32'd1);

    // Fan-out to all four slots.
    step(1'b0, 1'b1, 16'hAAAA, 2'd0, 4'b0000);
    check("fanout_b_untouched", {31'd0, vb}, 32'd0);
    step(1'b0, 1'b1, 16'hBBBB, 2'd1, 4'b0000);
    step(1'b0, 1'b1, 16'hCCCC, 2'd2, 4'b0000);
    step(1'b0, 1'b1, 16'hDDDD, 2'd3, 4'b0000);
    check("fanout_a", {16'd0, qa}, 32'hAAAA);
    check("fanout_d", {16'd0, qd}, 32'hDDDD);

    // Back-pressure on full B, then refill with same-cycle ack.
    step(1'b0, 1'b1, 16'h5555, 2'd1, 4'b0000);
    check("bp_b_held", {16'd0, qb}, 32'hBBBB);
    step(1'b0, 1'b1, 16'h5555, 2'd1, 4'b0010);
    check("refill_b", {16'd0, qb}, 32'h5555);
    check("refill_vb", {31'd0, vb}, 32'd1);

    // Drain A, then accept into A while C is acked.
    step(1'b0, 1'b0, 16'h0000, 2'd0, 4'b0001);
    step(1'b0, 1'b1, 16'h0F0F, 2'd0, 4'b0100);
    check("indep_a", {16'd0, qa}, 32'h0F0F);
    check("indep_vc", {31'd0, vc}, 32'd0);
    check("indep_c_kept", {16'd0, qc}, 32'hCCCC);

    // Drain D, then a spurious ack on empty D.
    step(1'b0, 1'b0, 16'h0000, 2'd0, 4'b1000);
    step(1'b0, 1'b0, 16'h9999, 2'd3, 4'b1000);
    check("spurious_d_kept", {16'd0, qd}, 32'hDDDD);

    // Refill C and D so all four are full, then reset with ack and offer.
    step(1'b0, 1'b1, 16'h3C3C, 2'd2, 4'b0000);
    step(1'b0, 1'b1, 16'h4D4D, 2'd3, 4'b0000);
    check("all_full", {28'd0, vd, vc, vb, va}, 32'hF);
    step(1'b1, 1'b1, 16'h7777, 2'd0, 4'b0001);
    check("midreset_valids", {28'd0, vd, vc, vb, va}, 32'h0);
    check("midreset_a", {16'd0, qa}, 32'h0);

    // Randomized traffic; the producer holds its offer while stalled.
    h_v = 1'b0; h_d = 16'h0; h_c = 2'd0; hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      r_v = ($urandom_range(0, 59) == 0);
      if (!hold) begin
        h_v = ($urandom_range(0, 3) != 0);
        h_d = 16'($urandom);
        h_c = 2'($urandom_range(0, 3));
      end
      r_ack = 4'($urandom) & 4'($urandom);
      step(r_v, h_v, h_d, h_c, r_ack);
      hold = h_v && !last_accept && !r_v;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
